// File: rtl/peripheral_msi_ahb3_initiator_pkg.sv
// peripheral_msi_ahb3_initiator_pkg: AHB3 encodings and FSM states shared by the MSI initiator
package peripheral_msi_ahb3_initiator_pkg;
  localparam logic [1:0] HTRANS_IDLE = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [2:0] HSIZE_WORD = 3'b010;
  localparam logic [2:0] HBURST_SINGLE = 3'b000;
  localparam logic [3:0] HPROT_DATA_PRIV = 4'b0011;
  typedef enum logic [1:0] {ST_IDLE, ST_ADDR, ST_DATA, ST_ERR} state_e;
endpackage

// File: rtl/peripheral_msi_priority_encoder.sv
// peripheral_msi_priority_encoder: selects the lowest-index pending vector
module peripheral_msi_priority_encoder #(
  parameter int VECTORS = 4
) (
  input  logic [VECTORS-1:0] req_i,
  output logic               any_o,
  output logic [3:0]         idx_o
);
  always_comb begin
    idx_o = '0;
    for (int i = VECTORS - 1; i >= 0; i--) idx_o = req_i[i] ? 4'(i) : idx_o;
  end
  assign any_o = |req_i;
endmodule

// File: rtl/peripheral_msi_ahb3_initiator.sv
// peripheral_msi_ahb3_initiator: turns interrupt edges into single AHB3 message writes
module peripheral_msi_ahb3_initiator
  import peripheral_msi_ahb3_initiator_pkg::*;
#(
  parameter int HADDR_SIZE = 32,
  parameter int HDATA_SIZE = 32,
  parameter int VECTORS    = 4
) (
  input  logic                  HCLK,
  input  logic                  HRESET,
  input  logic                  enable_i,
  input  logic [VECTORS-1:0]    irq_i,
  input  logic [HADDR_SIZE-1:0] msi_addr_i,
  input  logic [HDATA_SIZE-1:0] msi_data_i,
  input  logic [VECTORS-1:0]    err_clr_i,
  output logic [HADDR_SIZE-1:0] HADDR,
  output logic [HDATA_SIZE-1:0] HWDATA,
  output logic                  HWRITE,
  output logic                  HMASTLOCK,
  output logic [2:0]            HSIZE,
  output logic [2:0]            HBURST,
  output logic [3:0]            HPROT,
  output logic [1:0]            HTRANS,
  input  logic [HDATA_SIZE-1:0] HRDATA,
  input  logic                  HREADY,
  input  logic                  HRESP,
  output logic                  busy_o,
  output logic                  sent_o,
  output logic [VECTORS-1:0]    err_o
);
  state_e             state_q;
  logic [VECTORS-1:0] irq_q, pending_q, pending_d, err_q, err_d, sel_mask, rise;
  logic [3:0]         sel_q, next_idx;
  logic               any_pending, done_ok, done_err;
  logic               unused_ok;
  assign unused_ok = ^HRDATA;
  peripheral_msi_priority_encoder #(.VECTORS(VECTORS)) u_prio (
    .req_i(pending_q),
    .any_o(any_pending),
    .idx_o(next_idx)
  );
  // New edges are OR-ed in after the completion clear, so a fresh edge on sel survives
  always_comb begin
    rise      = irq_i & ~irq_q;
    sel_mask  = VECTORS'(1) << sel_q;
    done_ok   = state_q == ST_DATA && HREADY && !HRESP;
    done_err  = HREADY && (state_q == ST_ERR || (state_q == ST_DATA && HRESP));
    pending_d = (pending_q & ~({VECTORS{done_ok | done_err}} & sel_mask)) | rise;
    err_d     = (err_q & ~err_clr_i) | ({VECTORS{done_err}} & sel_mask);
  end
  always_ff @(posedge HCLK or posedge HRESET)
    if (HRESET) begin
      state_q   <= ST_IDLE;
      irq_q     <= '0;
      pending_q <= '0;
      err_q     <= '0;
      sel_q     <= '0;
      sent_o    <= 1'b0;
      HTRANS    <= HTRANS_IDLE;
      HADDR     <= '0;
      HWDATA    <= '0;
      HWRITE    <= 1'b0;
      HSIZE     <= '0;
      HBURST    <= '0;
      HPROT     <= '0;
      HMASTLOCK <= 1'b0;
    end else begin
      irq_q     <= irq_i;
      pending_q <= pending_d;
      err_q     <= err_d;
      sent_o    <= done_ok;
      case (state_q)
        ST_IDLE: if (enable_i && any_pending) begin
          state_q   <= ST_ADDR;
          sel_q     <= next_idx;
          HTRANS    <= HTRANS_NONSEQ;
          HADDR     <= msi_addr_i;
          HWRITE    <= 1'b1;
          HSIZE     <= HSIZE_WORD;
          HBURST    <= HBURST_SINGLE;
          HPROT     <= HPROT_DATA_PRIV;
          HMASTLOCK <= 1'b0;
        end
        ST_ADDR: if (HREADY) begin
          state_q <= ST_DATA;
          HTRANS  <= HTRANS_IDLE;
          HWDATA  <= msi_data_i + HDATA_SIZE'(sel_q);
        end
        ST_DATA: state_q <= (done_ok || done_err) ? ST_IDLE : (HRESP ? ST_ERR : ST_DATA);
        ST_ERR: state_q <= HREADY ? ST_IDLE : ST_ERR;
        default: state_q <= ST_IDLE;
      endcase
    end
  assign busy_o = state_q != ST_IDLE;
  assign err_o  = err_q;
endmodule
